// File: rtl/pipe_ctrl.sv
// Pipe scroller and BCD scorer: two pipes scroll left, respawn with LFSR gap heights.
// Optional build macro PIPE_SPEEDUP_EN shortens the scroll divider every ten points.
module pipe_ctrl #(
    parameter int SCREEN_W       = 640,
    parameter int SLOT_WIDTH     = 60,
    parameter int SLOT_HEIGHT    = 100,
    parameter int PIPE_SPACING   = 360,
    parameter int INIT_X         = 660,
    parameter int BIRD_LEFT      = 286,
    parameter int GAP_MIN        = 220,
    parameter int GAP_RANGE      = 240,
    parameter int SCROLL_DIV     = 8,
    parameter int SCROLL_DIV_MIN = 3
) (
    input  logic        clk_ms,
    input  logic        rst,
    input  logic [1:0]  state,
    output logic [9:0]  pip1_X,
    output logic [8:0]  pip1_Y,
    output logic [9:0]  pip2_X,
    output logic [8:0]  pip2_Y,
    output logic [15:0] score,
    output logic        score_pulse
);

    localparam logic [9:0] INIT_A    = 10'(INIT_X);
    localparam logic [9:0] INIT_B    = 10'(INIT_X + PIPE_SPACING);
    localparam logic [9:0] SPACING   = 10'(PIPE_SPACING);
    localparam logic [9:0] BIRD_X    = 10'(BIRD_LEFT);
    localparam logic [8:0] GAP_BASE  = 9'(GAP_MIN);
    localparam logic [8:0] GAP_SPAN  = 9'(GAP_RANGE);
    localparam int         Y_RST_I   = GAP_MIN + ((225 < GAP_RANGE) ? 225 : 225 - GAP_RANGE);
    localparam logic [8:0] Y_RST     = 9'(Y_RST_I);
    localparam logic [5:0] DIV_INIT  = 6'(SCROLL_DIV);

    localparam logic [1:0] ST_READY  = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;

    logic [15:0] lfsr;
    logic [9:0]  ax, bx;
    logic [8:0]  ay, by;
    logic        lead;          // 0: pipe A leads, 1: pipe B leads
    logic [5:0]  cnt;
    logic [5:0]  div;
    logic [15:0] score_r;
    logic        pulse_r;

    logic [15:0] lfsr_nx;
    logic [9:0]  ax_nx, bx_nx;
    logic [8:0]  ay_nx, by_nx;
    logic        lead_nx;
    logic [5:0]  cnt_nx;
    logic [15:0] score_nx;
    logic        pulse_nx;
    logic [5:0]  div_nx;
    logic        step;
    logic [9:0]  lead_x;
    logic [8:0]  r_ext;
    logic [8:0]  y_new;
    logic        sel_a;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] o;
        logic        c;
        o = v;
        if (v == 16'h9999) begin
            return v;
        end
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    o[d*4 +: 4] = 4'd0;
                end else begin
                    o[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return o;
    endfunction

    assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign r_ext   = {1'b0, lfsr[7:0]};
    assign y_new   = GAP_BASE + ((r_ext < GAP_SPAN) ? r_ext : (r_ext - GAP_SPAN));
    assign lead_x  = lead ? bx : ax;

`ifdef PIPE_SPEEDUP_EN
    localparam logic [5:0] DIV_MIN = 6'(SCROLL_DIV_MIN);
    always_ff @(posedge clk_ms or posedge rst) begin
        if (rst) begin
            div <= DIV_INIT;
        end else begin
            div <= div_nx;
        end
    end
`else
    assign div = DIV_INIT;
`endif

    always_comb begin
        ax_nx    = ax;
        bx_nx    = bx;
        ay_nx    = ay;
        by_nx    = by;
        lead_nx  = lead;
        cnt_nx   = cnt;
        score_nx = score_r;
        pulse_nx = 1'b0;
        div_nx   = div;
        step     = 1'b0;
        case (state)
            ST_READY: begin
                ax_nx    = INIT_A;
                bx_nx    = INIT_B;
                ay_nx    = y_new;
                by_nx    = y_new;
                lead_nx  = 1'b0;
                cnt_nx   = 6'd0;
                score_nx = 16'h0000;
                div_nx   = DIV_INIT;
            end
            ST_PLAY: begin
                if (cnt == div - 6'd1) begin
                    step   = 1'b1;
                    cnt_nx = 6'd0;
                end else begin
                    cnt_nx = cnt + 6'd1;
                end
                if (step) begin
                    ax_nx = ax - 10'd1;
                    bx_nx = bx - 10'd1;
                    // The lead pipe at the left edge wraps behind the trailer instead of moving.
                    if (lead_x == 10'd0) begin
                        lead_nx = ~lead;
                        if (lead) begin
                            bx_nx = ax - 10'd1 + SPACING;
                            by_nx = y_new;
                        end else begin
                            ax_nx = bx - 10'd1 + SPACING;
                            ay_nx = y_new;
                        end
                    end else if (lead_x == BIRD_X) begin
                        score_nx = bcd_inc(score_r);
                        pulse_nx = (score_nx != score_r);
`ifdef PIPE_SPEEDUP_EN
                        if (pulse_nx && score_nx[3:0] == 4'd0 && div > DIV_MIN) begin
                            div_nx = div - 6'd1;
                        end
`endif
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // pip1 is the nearest pipe the bird has not yet cleared, judged on next-state values.
    always_comb begin
        if (!lead_nx) begin
            sel_a = (ax_nx >= BIRD_X);
        end else begin
            sel_a = !(bx_nx >= BIRD_X);
        end
    end

    always_ff @(posedge clk_ms or posedge rst) begin
        if (rst) begin
            lfsr    <= 16'hACE1;
            ax      <= INIT_A;
            bx      <= INIT_B;
            ay      <= Y_RST;
            by      <= Y_RST;
            lead    <= 1'b0;
            cnt     <= 6'd0;
            score_r <= 16'h0000;
            pulse_r <= 1'b0;
            pip1_X  <= INIT_A;
            pip1_Y  <= Y_RST;
            pip2_X  <= INIT_B;
            pip2_Y  <= Y_RST;
        end else begin
            lfsr    <= lfsr_nx;
            ax      <= ax_nx;
            bx      <= bx_nx;
            ay      <= ay_nx;
            by      <= by_nx;
            lead    <= lead_nx;
            cnt     <= cnt_nx;
            score_r <= score_nx;
            pulse_r <= pulse_nx;
            if (sel_a) begin
                pip1_X <= ax_nx;
                pip1_Y <= ay_nx;
                pip2_X <= bx_nx;
                pip2_Y <= by_nx;
            end else begin
                pip1_X <= bx_nx;
                pip1_Y <= by_nx;
                pip2_X <= ax_nx;
                pip2_Y <= ay_nx;
            end
        end
    end

    assign score       = score_r;
    assign score_pulse = pulse_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for scroll/score/respawn, hand sequences for BCD and reset.
module tb_pipe_ctrl;

    logic        clk_ms;
    logic        rst;
    logic [1:0]  state;
    logic [9:0]  pip1_X;
    logic [8:0]  pip1_Y;
    logic [9:0]  pip2_X;
    logic [8:0]  pip2_Y;
    logic [15:0] score;
    logic        score_pulse;

    int total  = 0;
    int passed = 0;

    pipe_ctrl dut (
        .clk_ms      (clk_ms),
        .rst         (rst),
        .state       (state),
        .pip1_X      (pip1_X),
        .pip1_Y      (pip1_Y),
        .pip2_X      (pip2_X),
        .pip2_Y      (pip2_Y),
        .score       (score),
        .score_pulse (score_pulse)
    );

    initial begin
        clk_ms = 1'b0;
        forever #5 clk_ms = ~clk_ms;
    end

    typedef struct {
        logic [1:0]  st;
        int          cyc;
        logic [9:0]  p1x;
        logic [9:0]  p2x;
        logic [15:0] sc;
        logic        pl;
        logic        chk_y;
    } vec_t;

    vec_t vecs[11];

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_ms);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_rng(input string name, input logic [8:0] act);
        total++;
        if (act >= 9'd220 && act <= 9'd459) passed++;
        else $display("FAIL %s: got %0d expected 220..459", name, act);
    endtask

    initial begin
        // state, cycles, pip1_X, pip2_X, score, pulse, check Y range
        vecs[0]  = '{2'd0, 100,  10'd660, 10'd1020, 16'h0000, 1'b0, 1'b1};
        vecs[1]  = '{2'd1, 2992, 10'd286, 10'd646,  16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{2'd1, 8,    10'd645, 10'd285,  16'h0001, 1'b1, 1'b0};
        vecs[3]  = '{2'd1, 1,    10'd645, 10'd285,  16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{2'd2, 500,  10'd645, 10'd285,  16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{2'd1, 7,    10'd644, 10'd284,  16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{2'd1, 2272, 10'd360, 10'd0,    16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{2'd1, 8,    10'd359, 10'd719,  16'h0001, 1'b0, 1'b1};
        vecs[8]  = '{2'd1, 584,  10'd286, 10'd646,  16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{2'd1, 8,    10'd645, 10'd285,  16'h0002, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 1,    10'd660, 10'd1020, 16'h0000, 1'b0, 1'b1};

        rst   = 1'b1;
        state = 2'd0;
        #12;
        check("rst_p1x", {6'd0, pip1_X}, 16'd660);
        check("rst_p2x", {6'd0, pip2_X}, 16'd1020);
        check("rst_p1y", {7'd0, pip1_Y}, 16'd445);
        check("rst_p2y", {7'd0, pip2_Y}, 16'd445);
        check("rst_score", score, 16'h0000);
        check("rst_pulse", {15'd0, score_pulse}, 16'd0);
        @(posedge clk_ms);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            state = vecs[i].st;
            cycles(vecs[i].cyc);
            check($sformatf("v%0d_p1x", i), {6'd0, pip1_X}, {6'd0, vecs[i].p1x});
            check($sformatf("v%0d_p2x", i), {6'd0, pip2_X}, {6'd0, vecs[i].p2x});
            check($sformatf("v%0d_score", i), score, vecs[i].sc);
            check($sformatf("v%0d_pulse", i), {15'd0, score_pulse}, {15'd0, vecs[i].pl});
            if (vecs[i].chk_y) begin
                check_rng($sformatf("v%0d_p1y", i), pip1_Y);
                check_rng($sformatf("v%0d_p2y", i), pip2_Y);
            end
        end

        // BCD carry across three digits
        state = 2'd1;
        cycles(2992);
        check("bcd_pre_p1x", {6'd0, pip1_X}, 16'd286);
        state = 2'd2;
        cycles(1);
        force dut.score_r = 16'h0999;
        cycles(1);
        release dut.score_r;
        state = 2'd1;
        cycles(8);
        check("bcd_carry_score", score, 16'h1000);
        check("bcd_carry_pulse", {15'd0, score_pulse}, 16'd1);
        check("bcd_carry_p1x", {6'd0, pip1_X}, 16'd645);

        // Saturation at 9999: no change and no strobe
        cycles(2872);
        check("sat_pre_p1x", {6'd0, pip1_X}, 16'd286);
        check("sat_pre_p2x", {6'd0, pip2_X}, 16'd646);
        state = 2'd2;
        cycles(1);
        force dut.score_r = 16'h9999;
        cycles(1);
        release dut.score_r;
        state = 2'd1;
        cycles(8);
        check("sat_score", score, 16'h9999);
        check("sat_pulse", {15'd0, score_pulse}, 16'd0);
        check("sat_p1x", {6'd0, pip1_X}, 16'd645);
        check("sat_p2x", {6'd0, pip2_X}, 16'd285);

        // Asynchronous reset takes effect between clock edges
        cycles(3);
        #2;
        rst = 1'b1;
        #1;
        check("async_p1x", {6'd0, pip1_X}, 16'd660);
        check("async_p2x", {6'd0, pip2_X}, 16'd1020);
        check("async_score", score, 16'h0000);
        check("async_p1y", {7'd0, pip1_Y}, 16'd445);
        cycles(1);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
